// File: rtl/bru_pred_pkg.sv
// ---------------------------------------------------------------------------
// bru_pred_pkg
//   Shared types and constants for the branch resolution / prediction unit.
//   - bht_cnt_e : 2-bit bimodal counter encodings (SNT/WNT/WT/ST)
//   - FUNC3_*   : RISC-V branch funct3 encodings
//   - bht_next  : saturating counter update helper
// ---------------------------------------------------------------------------
package bru_pred_pkg;

    typedef enum logic [1:0] {
        BHT_SNT = 2'd0,
        BHT_WNT = 2'd1,
        BHT_WT  = 2'd2,
        BHT_ST  = 2'd3
    } bht_cnt_e;

    localparam logic [2:0] FUNC3_BEQ  = 3'b000;
    localparam logic [2:0] FUNC3_BNE  = 3'b001;
    localparam logic [2:0] FUNC3_BLT  = 3'b100;
    localparam logic [2:0] FUNC3_BGE  = 3'b101;
    localparam logic [2:0] FUNC3_BLTU = 3'b110;
    localparam logic [2:0] FUNC3_BGEU = 3'b111;

    // Saturating 2-bit counter: count up on taken, down on not-taken.
    function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
        bht_cnt_e nxt;
        nxt = cur;
        if (taken && cur != BHT_ST) begin
            nxt = bht_cnt_e'(cur + 2'd1);
        end else if (!taken && cur != BHT_SNT) begin
            nxt = bht_cnt_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bru_pred_if.sv
// ---------------------------------------------------------------------------
// bru_pred_if
//   Bundle of the ID-stage resolution signals handed to the branch unit.
//   master : the decode stage driving the instruction under resolution
//   slave  : bru_pred consuming it
//   Signals: idu_fire, idupc, idu_pred_taken, idu_pred_pc,
//            jal/jalr/brch (one-hot or zero), bfun3, rs1, rs2, imm
// ---------------------------------------------------------------------------
interface bru_pred_if #(
    parameter int XLEN = 64
);
    logic            idu_fire;
    logic [XLEN-1:0] idupc;
    logic            idu_pred_taken;
    logic [XLEN-1:0] idu_pred_pc;
    logic            jal;
    logic            jalr;
    logic            brch;
    logic [2:0]      bfun3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;

    modport master (
        output idu_fire, idupc, idu_pred_taken, idu_pred_pc,
               jal, jalr, brch, bfun3, rs1, rs2, imm
    );

    modport slave (
        input  idu_fire, idupc, idu_pred_taken, idu_pred_pc,
               jal, jalr, brch, bfun3, rs1, rs2, imm
    );
endinterface

// File: rtl/bru_pred_cond.sv
// ---------------------------------------------------------------------------
// bru_cond
//   Purely combinational branch condition evaluation.
//   i_rs1, i_rs2 : forwarded operands
//   i_bfun3      : branch funct3
//   o_cond       : condition true; 0 for any non-branch funct3
// ---------------------------------------------------------------------------
module bru_cond
    import bru_pred_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_bfun3,
    output logic            o_cond
);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        o_cond = 1'b0;
        case (i_bfun3)
            FUNC3_BEQ:  o_cond = (i_rs1 == i_rs2);
            FUNC3_BNE:  o_cond = (i_rs1 != i_rs2);
            FUNC3_BLT:  o_cond = ($signed(i_rs1) <  $signed(i_rs2));
            FUNC3_BGE:  o_cond = ($signed(i_rs1) >= $signed(i_rs2));
            FUNC3_BLTU: o_cond = (i_rs1 <  i_rs2);
            FUNC3_BGEU: o_cond = (i_rs1 >= i_rs2);
            default:    o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/bru_pred.sv
// ---------------------------------------------------------------------------
// bru_pred
//   Branch resolution unit with dynamic prediction between IFU and IDU.
//   Predicts the next fetch PC from a direct-mapped BTB plus a bimodal BHT,
//   resolves jal/jalr/branches in ID, and redirects/squashes on mispredict.
//
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_ifupc                 : current fetch PC
//   o_pred_taken, o_pred_pc : prediction for i_ifupc
//   idu (bru_pred_if.slave) : instruction being resolved in ID
//   i_iru_jump, i_iru_pc    : trap/interrupt redirect
//   i_fence_jump, i_fence_pc: fence redirect (highest priority)
//   i_flush                 : invalidate all BTB entries
//   o_next_pc, o_ifid_nop   : next fetch PC, IF/ID squash
//   o_br_cnt, o_mispred_cnt : resolved transfers / mispredictions
// ---------------------------------------------------------------------------
module bru_pred
    import bru_pred_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 64,
    parameter int BTB_DEPTH = 16,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [XLEN-1:0]  i_ifupc,
    output logic             o_pred_taken,
    output logic [XLEN-1:0]  o_pred_pc,
    bru_pred_if.slave        idu,
    input  logic             i_iru_jump,
    input  logic [XLEN-1:0]  i_iru_pc,
    input  logic             i_fence_jump,
    input  logic [XLEN-1:0]  i_fence_pc,
    input  logic             i_flush,
    output logic [XLEN-1:0]  o_next_pc,
    output logic             o_ifid_nop,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int BHT_IW  = $clog2(BHT_DEPTH);
    localparam int BTB_IW  = $clog2(BTB_DEPTH);
    localparam int TAG_LSB = BTB_IW + 2;

    typedef struct packed {
        logic             valid;
        logic             is_jal;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } btb_entry_t;

    // Everything but the valid bit; kept apart so only valid needs a reset.
    typedef struct packed {
        logic             is_jal;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } btb_payload_t;

    // ---------------- storage ----------------
    logic [BTB_DEPTH-1:0] btb_valid;
    btb_payload_t         btb_pay [BTB_DEPTH];
    bht_cnt_e             bht     [BHT_DEPTH];
    logic [CNT_W-1:0]     br_cnt;
    logic [CNT_W-1:0]     mispred_cnt;

    // ---------------- prediction (fetch side) ----------------
    logic [BTB_IW-1:0] if_btb_idx;
    logic [BHT_IW-1:0] if_bht_idx;
    logic [TAG_W-1:0]  if_tag;
    btb_entry_t        if_entry;
    bht_cnt_e          if_cnt;
    logic              if_hit;
    logic [XLEN-1:0]   if_seq_pc;

    assign if_btb_idx = i_ifupc[BTB_IW+1:2];
    assign if_bht_idx = i_ifupc[BHT_IW+1:2];
    assign if_tag     = i_ifupc[TAG_LSB +: TAG_W];
    assign if_seq_pc  = i_ifupc + XLEN'(4);
    assign if_cnt     = bht[if_bht_idx];

    always_comb begin
        if_entry        = '0;
        if_entry.valid  = btb_valid[if_btb_idx];
        if_entry.is_jal = btb_pay[if_btb_idx].is_jal;
        if_entry.tag    = btb_pay[if_btb_idx].tag;
        if_entry.target = btb_pay[if_btb_idx].target;
    end

    assign if_hit = if_entry.valid && (if_entry.tag == if_tag);

    always_comb begin
        o_pred_taken = 1'b0;
        o_pred_pc    = if_seq_pc;
        if (if_hit) begin
            o_pred_pc    = if_entry.target;
            // Jumps are unconditional; branches follow the counter's MSB.
            o_pred_taken = if_entry.is_jal || (if_cnt >= BHT_WT);
        end
        if (!i_rst_n) begin
            o_pred_taken = 1'b0;
        end
    end

    // ---------------- resolution (ID side) ----------------
    logic              cond;
    logic              act_taken;
    logic [XLEN-1:0]   act_pc;
    logic [XLEN-1:0]   fix_pc;
    logic              valid_upd;
    logic              mispred;
    logic              is_ctrl;
    logic              btb_we;
    logic [BTB_IW-1:0] id_btb_idx;
    logic [BHT_IW-1:0] id_bht_idx;
    logic [TAG_W-1:0]  id_tag;

    bru_cond #(.XLEN(XLEN)) u_cond (
        .i_rs1   (idu.rs1),
        .i_rs2   (idu.rs2),
        .i_bfun3 (idu.bfun3),
        .o_cond  (cond)
    );

    assign id_btb_idx = idu.idupc[BTB_IW+1:2];
    assign id_bht_idx = idu.idupc[BHT_IW+1:2];
    assign id_tag     = idu.idupc[TAG_LSB +: TAG_W];

    assign is_ctrl   = idu.jal || idu.jalr || idu.brch;
    assign act_taken = idu.jal || idu.jalr || (idu.brch && cond);
    assign act_pc    = idu.jalr ? ((idu.rs1 + idu.imm) & ~XLEN'(1))
                                : (idu.idupc + idu.imm);
    assign fix_pc    = act_taken ? act_pc : (idu.idupc + XLEN'(4));

    // Reset is folded in so nothing resolves or updates while held in reset.
    assign valid_upd = i_rst_n && idu.idu_fire && !i_iru_jump && !i_fence_jump;
    assign mispred   = valid_upd &&
                       ((act_taken != idu.idu_pred_taken) ||
                        (act_taken && (act_pc != idu.idu_pred_pc)));

    // jalr targets depend on a register, so they are never cached.
    assign btb_we = valid_upd && act_taken && !idu.jalr;

    always_comb begin
        o_next_pc = if_seq_pc;
        if (i_fence_jump) begin
            o_next_pc = i_fence_pc;
        end else if (i_iru_jump) begin
            o_next_pc = i_iru_pc;
        end else if (mispred) begin
            o_next_pc = fix_pc;
        end else if (o_pred_taken) begin
            o_next_pc = o_pred_pc;
        end
    end

    assign o_ifid_nop = mispred;

    // ---------------- state update ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            btb_valid   <= '0;
            br_cnt      <= '0;
            mispred_cnt <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= BHT_WNT;
            end
        end else begin
            if (valid_upd && idu.brch) begin
                bht[id_bht_idx] <= bht_next(bht[id_bht_idx], act_taken);
            end
            // Flush takes precedence over a coincident BTB write.
            if (i_flush) begin
                btb_valid <= '0;
            end else if (btb_we) begin
                btb_valid[id_btb_idx] <= 1'b1;
            end
            if (valid_upd && is_ctrl) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (mispred) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: the BTB payload array has no reset; a stale payload is harmless
    // because the separately reset valid bit gates every lookup.
    always_ff @(posedge i_clk) begin
        if (btb_we) begin
            btb_pay[id_btb_idx] <= '{is_jal: idu.jal, tag: id_tag, target: act_pc};
        end
    end

    assign o_br_cnt      = br_cnt;
    assign o_mispred_cnt = mispred_cnt;

endmodule

// File: tb/tb_bru_pred.sv
// ---------------------------------------------------------------------------
// tb_bru_pred
//   Self-checking bench for bru_pred. A behavioural model of the predictor
//   tables and counters is checked against the DUT every cycle, and directed
//   scenarios pin specific outputs to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_bru_pred;

    localparam int XLEN      = 64;
    localparam int BHT_DEPTH = 64;
    localparam int BTB_DEPTH = 16;
    localparam int TAG_W     = 8;
    localparam int CNT_W     = 32;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [XLEN-1:0]   i_ifupc;
    logic              o_pred_taken;
    logic [XLEN-1:0]   o_pred_pc;
    logic              i_iru_jump;
    logic [XLEN-1:0]   i_iru_pc;
    logic              i_fence_jump;
    logic [XLEN-1:0]   i_fence_pc;
    logic              i_flush;
    logic [XLEN-1:0]   o_next_pc;
    logic              o_ifid_nop;
    logic [CNT_W-1:0]  o_br_cnt;
    logic [CNT_W-1:0]  o_mispred_cnt;

    bru_pred_if #(.XLEN(XLEN)) idu ();

    bru_pred #(
        .XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .BTB_DEPTH(BTB_DEPTH),
        .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_ifupc       (i_ifupc),
        .o_pred_taken  (o_pred_taken),
        .o_pred_pc     (o_pred_pc),
        .idu           (idu),
        .i_iru_jump    (i_iru_jump),
        .i_iru_pc      (i_iru_pc),
        .i_fence_jump  (i_fence_jump),
        .i_fence_pc    (i_fence_pc),
        .i_flush       (i_flush),
        .o_next_pc     (o_next_pc),
        .o_ifid_nop    (o_ifid_nop),
        .o_br_cnt      (o_br_cnt),
        .o_mispred_cnt (o_mispred_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          mv   [BTB_DEPTH];
    bit          mj   [BTB_DEPTH];
    logic [63:0] mtag [BTB_DEPTH];
    logic [63:0] mtgt [BTB_DEPTH];
    int          mbht [BHT_DEPTH];
    int unsigned mbr  = 0;
    int unsigned mmis = 0;
    bit          armed = 1'b0;

    typedef struct {
        bit          taken;
        logic [63:0] pc;
        bit          valid;
        bit          mis;
    } res_t;

    function automatic int slot_btb(input logic [63:0] pc);
        return int'((pc / 4) % BTB_DEPTH);
    endfunction

    function automatic int slot_bht(input logic [63:0] pc);
        return int'((pc / 4) % BHT_DEPTH);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] pc);
        return (pc / (4 * BTB_DEPTH)) % (64'd1 << TAG_W);
    endfunction

    function automatic bit m_cond(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic res_t m_resolve();
        res_t r;
        r.taken = idu.jal || idu.jalr || (idu.brch && m_cond(idu.bfun3, idu.rs1, idu.rs2));
        r.pc    = idu.jalr ? ((idu.rs1 + idu.imm) & ~64'd1) : (idu.idupc + idu.imm);
        r.valid = i_rst_n && idu.idu_fire && !i_iru_jump && !i_fence_jump;
        r.mis   = r.valid && ((r.taken != idu.idu_pred_taken) ||
                              (r.taken && r.pc != idu.idu_pred_pc));
        return r;
    endfunction

    // Model state advances on the same edge as the DUT.
    always @(posedge i_clk) begin
        res_t r;
        int   bi;
        int   hi;
        r  = m_resolve();
        bi = slot_btb(idu.idupc);
        hi = slot_bht(idu.idupc);
        if (!i_rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) mv[i] <= 1'b0;
            for (int i = 0; i < BHT_DEPTH; i++) mbht[i] <= 1;
            mbr   <= 0;
            mmis  <= 0;
            armed <= 1'b1;
        end else begin
            if (r.valid && idu.brch)
                mbht[hi] <= r.taken ? ((mbht[hi] < 3) ? mbht[hi] + 1 : 3)
                                    : ((mbht[hi] > 0) ? mbht[hi] - 1 : 0);
            if (i_flush) begin
                for (int i = 0; i < BTB_DEPTH; i++) mv[i] <= 1'b0;
            end else if (r.valid && (idu.jal || (idu.brch && r.taken))) begin
                mv[bi]   <= 1'b1;
                mj[bi]   <= idu.jal;
                mtag[bi] <= tag_of(idu.idupc);
                mtgt[bi] <= r.pc;
            end
            if (r.valid && (idu.jal || idu.jalr || idu.brch)) mbr <= mbr + 1;
            if (r.mis) mmis <= mmis + 1;
        end
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge i_clk) begin
        res_t        r;
        bit          hit;
        bit          pt;
        logic [63:0] pp;
        logic [63:0] np;
        int          bi;
        if (armed) begin
            r   = m_resolve();
            bi  = slot_btb(i_ifupc);
            hit = mv[bi] && (mtag[bi] == tag_of(i_ifupc));
            pp  = hit ? mtgt[bi] : i_ifupc + 64'd4;
            pt  = i_rst_n && hit && (mj[bi] || mbht[slot_bht(i_ifupc)] >= 2);
            if (i_fence_jump)    np = i_fence_pc;
            else if (i_iru_jump) np = i_iru_pc;
            else if (r.mis)      np = r.taken ? r.pc : idu.idupc + 64'd4;
            else if (pt)         np = pp;
            else                 np = i_ifupc + 64'd4;
            check("model pred_taken", 64'(o_pred_taken), 64'(pt));
            check("model pred_pc",    o_pred_pc, pp);
            check("model next_pc",    o_next_pc, np);
            check("model ifid_nop",   64'(o_ifid_nop), 64'(r.mis));
            check("model br_cnt",     64'(o_br_cnt), 64'(mbr));
            check("model mispred_cnt", 64'(o_mispred_cnt), 64'(mmis));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge i_clk);
        #1;
    endtask

    task automatic idle();
        idu.idu_fire       = 1'b0;
        idu.idupc          = '0;
        idu.idu_pred_taken = 1'b0;
        idu.idu_pred_pc    = '0;
        idu.jal            = 1'b0;
        idu.jalr           = 1'b0;
        idu.brch           = 1'b0;
        idu.bfun3          = '0;
        idu.rs1            = '0;
        idu.rs2            = '0;
        idu.imm            = '0;
        i_iru_jump         = 1'b0;
        i_iru_pc           = '0;
        i_fence_jump       = 1'b0;
        i_fence_pc         = '0;
        i_flush            = 1'b0;
    endtask

    task automatic resolve(input logic [63:0] pc, input bit j, input bit jr, input bit br,
                           input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] im, input bit pt, input logic [63:0] ppc);
        idle();
        idu.idu_fire       = 1'b1;
        idu.idupc          = pc;
        idu.jal            = j;
        idu.jalr           = jr;
        idu.brch           = br;
        idu.bfun3          = f3;
        idu.rs1            = a;
        idu.rs2            = b;
        idu.imm            = im;
        idu.idu_pred_taken = pt;
        idu.idu_pred_pc    = ppc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  cond_exp;
        logic [63:0] pc;
        cond_exp = 8'b1001_0010;

        idle();
        i_rst_n = 1'b0;
        i_ifupc = 64'h8000_0000;
        next_cycle();
        next_cycle();
        i_rst_n = 1'b1;
        settle();
        check("reset pred_taken", 64'(o_pred_taken), 64'd0);
        check("reset next_pc", o_next_pc, 64'h8000_0004);
        check("reset br_cnt", 64'(o_br_cnt), 64'd0);
        check("reset mispred_cnt", 64'(o_mispred_cnt), 64'd0);

        // BEQ taken, predicted not-taken.
        next_cycle();
        resolve(64'h100, 0, 0, 1, 3'd0, 64'd5, 64'd5, 64'h40, 0, 64'h104);
        settle();
        check("beq mispred nop", 64'(o_ifid_nop), 64'd1);
        check("beq mispred next_pc", o_next_pc, 64'h140);
        next_cycle();
        idle();
        i_ifupc = 64'h100;
        settle();
        check("beq learned taken", 64'(o_pred_taken), 64'd1);
        check("beq learned pc", o_pred_pc, 64'h140);
        check("beq learned next_pc", o_next_pc, 64'h140);

        // Same BEQ not-taken twice: counter 2 -> 1 -> 0.
        next_cycle();
        resolve(64'h100, 0, 0, 1, 3'd0, 64'd5, 64'd6, 64'h40, 1, 64'h140);
        settle();
        check("beq nt mispred nop", 64'(o_ifid_nop), 64'd1);
        check("beq nt fix pc", o_next_pc, 64'h104);
        next_cycle();
        resolve(64'h100, 0, 0, 1, 3'd0, 64'd5, 64'd6, 64'h40, 0, 64'h104);
        settle();
        check("beq nt correct nop", 64'(o_ifid_nop), 64'd0);
        check("beq nt weak next_pc", o_next_pc, 64'h104);
        next_cycle();
        idle();
        settle();
        check("beq cold pred_taken", 64'(o_pred_taken), 64'd0);
        check("beq entry kept", o_pred_pc, 64'h140);
        check("cnt after beq br", 64'(o_br_cnt), 64'd3);
        check("cnt after beq mis", 64'(o_mispred_cnt), 64'd2);

        // JAL learn, then predicted correctly.
        next_cycle();
        i_ifupc = 64'h8000_0000;
        resolve(64'h208, 1, 0, 0, 3'd0, 64'd0, 64'd0, 64'h10, 0, 64'h20c);
        settle();
        check("jal first nop", 64'(o_ifid_nop), 64'd1);
        check("jal first next_pc", o_next_pc, 64'h218);
        next_cycle();
        idle();
        i_ifupc = 64'h208;
        settle();
        check("jal hit taken", 64'(o_pred_taken), 64'd1);
        check("jal hit pc", o_pred_pc, 64'h218);
        next_cycle();
        resolve(64'h208, 1, 0, 0, 3'd0, 64'd0, 64'd0, 64'h10, 1, 64'h218);
        settle();
        check("jal correct nop", 64'(o_ifid_nop), 64'd0);
        check("jal correct next_pc", o_next_pc, 64'h218);
        next_cycle();
        idle();
        settle();
        check("jal mispred_cnt", 64'(o_mispred_cnt), 64'd3);
        check("jal br_cnt", 64'(o_br_cnt), 64'd5);

        // JALR: target LSB cleared, never cached.
        next_cycle();
        i_ifupc = 64'h8000_0000;
        resolve(64'h30c, 0, 1, 0, 3'd0, 64'h1001, 64'd0, 64'd2, 0, 64'h310);
        settle();
        check("jalr nop", 64'(o_ifid_nop), 64'd1);
        check("jalr next_pc", o_next_pc, 64'h1002);
        next_cycle();
        idle();
        i_ifupc = 64'h30c;
        settle();
        check("jalr not cached taken", 64'(o_pred_taken), 64'd0);
        check("jalr not cached pc", o_pred_pc, 64'h310);

        // funct3 sweep with rs1 = -1, rs2 = 1.
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            pc = 64'h1020 + 64'(4 * k);
            resolve(pc, 0, 0, 1, 3'(k), '1, 64'd1, 64'h40, 0, pc + 64'd4);
            settle();
            check($sformatf("funct3 %0d nop", k), 64'(o_ifid_nop), 64'(cond_exp[k]));
        end
        next_cycle();
        idle();
        i_ifupc = 64'h1024;
        settle();
        check("bne learned taken", 64'(o_pred_taken), 64'd1);
        check("bne learned pc", o_pred_pc, 64'h1064);
        check("sweep br_cnt", 64'(o_br_cnt), 64'd14);
        check("sweep mispred_cnt", 64'(o_mispred_cnt), 64'd7);

        // Stalled ID with jump decoded: nothing happens.
        next_cycle();
        idle();
        i_ifupc = 64'h8000_0000;
        idu.jal = 1'b1;
        idu.idupc = 64'h600;
        idu.imm = 64'h80;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("stall nop", 64'(o_ifid_nop), 64'd0);
            check("stall next_pc", o_next_pc, 64'h8000_0004);
            next_cycle();
        end

        // Fence and iru override a mispredicting resolution.
        resolve(64'h400, 0, 0, 1, 3'd0, 64'd7, 64'd7, 64'd8, 0, 64'h404);
        i_fence_jump = 1'b1;
        i_fence_pc   = 64'h300;
        i_iru_jump   = 1'b1;
        i_iru_pc     = 64'h700;
        settle();
        check("fence next_pc", o_next_pc, 64'h300);
        check("fence nop", 64'(o_ifid_nop), 64'd0);
        next_cycle();
        i_fence_jump = 1'b0;
        settle();
        check("iru next_pc", o_next_pc, 64'h700);
        check("iru nop", 64'(o_ifid_nop), 64'd0);
        next_cycle();
        idle();
        i_ifupc = 64'h400;
        settle();
        check("fence no btb write", o_pred_pc, 64'h404);
        check("fence br_cnt", 64'(o_br_cnt), 64'd14);
        check("fence mispred_cnt", 64'(o_mispred_cnt), 64'd7);

        // Flush coinciding with a JAL write: flush wins.
        next_cycle();
        resolve(64'h20c, 1, 0, 0, 3'd0, 64'd0, 64'd0, 64'h20, 0, 64'h210);
        i_flush = 1'b1;
        settle();
        check("flush jal nop", 64'(o_ifid_nop), 64'd1);
        check("flush jal next_pc", o_next_pc, 64'h22c);
        next_cycle();
        idle();
        i_ifupc = 64'h208;
        settle();
        check("flushed 208 taken", 64'(o_pred_taken), 64'd0);
        check("flushed 208 pc", o_pred_pc, 64'h20c);
        next_cycle();
        i_ifupc = 64'h20c;
        settle();
        check("flush beats write", o_pred_pc, 64'h210);
        next_cycle();
        i_ifupc = 64'h1024;
        settle();
        check("flushed 1024 pc", o_pred_pc, 64'h1028);
        next_cycle();
        i_ifupc = 64'h100;
        settle();
        check("flushed 100 pc", o_pred_pc, 64'h104);
        check("flush br_cnt", 64'(o_br_cnt), 64'd15);
        check("flush mispred_cnt", 64'(o_mispred_cnt), 64'd8);

        // Reset mid-run: prediction forced off, no resolution.
        next_cycle();
        resolve(64'h208, 1, 0, 0, 3'd0, 64'd0, 64'd0, 64'h10, 0, 64'h20c);
        settle();
        check("relearn nop", 64'(o_ifid_nop), 64'd1);
        next_cycle();
        idle();
        i_ifupc = 64'h208;
        settle();
        check("relearn taken", 64'(o_pred_taken), 64'd1);
        next_cycle();
        resolve(64'h100, 0, 0, 1, 3'd0, 64'd5, 64'd5, 64'h40, 0, 64'h104);
        i_rst_n = 1'b0;
        settle();
        check("in reset taken", 64'(o_pred_taken), 64'd0);
        check("in reset nop", 64'(o_ifid_nop), 64'd0);
        check("in reset next_pc", o_next_pc, 64'h20c);
        next_cycle();
        idle();
        i_rst_n = 1'b1;
        settle();
        check("post reset br_cnt", 64'(o_br_cnt), 64'd0);
        check("post reset mispred_cnt", 64'(o_mispred_cnt), 64'd0);
        check("post reset miss", o_pred_pc, 64'h20c);

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
